// File: rtl/run_limit_tx_if.sv
// Word-in / serial-out bundle for run_limit_tx: producer handshake plus line outputs.
interface run_limit_tx_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              w;
  logic              frame;
  logic              stuff;

  modport master (output data_in, valid, input ready, w, frame, stuff);
  modport slave  (input data_in, valid, output ready, w, frame, stuff);
endinterface

// File: rtl/run_limit_tx.sv
// Bit-stuffing serializer: LSB-first, complement bit after every run of two equal line bits.
// Define RUN_LIMIT_TX_PARITY_EN to append an even-parity bit (which may itself be stuffed).
module run_limit_tx #(
  parameter int DATA_W = 8
) (
  input  logic            clk,
  input  logic            reset,
  run_limit_tx_if.slave   bus
);

  localparam int                IDX_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;
  localparam logic [IDX_W-1:0]  LAST  = IDX_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    STUFF  = 2'd2
`ifdef RUN_LIMIT_TX_PARITY_EN
    ,PARITY = 2'd3
`endif
  } state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              run2_q, run2_d;   // bit currently on w completed a run of two
  logic              w_q, w_d;
  logic              frame_q, frame_d;
  logic              stuff_q, stuff_d;
  logic              ready_q, ready_d;
`ifdef RUN_LIMIT_TX_PARITY_EN
  logic              par_q, par_d;
  logic              par_sent_q, par_sent_d;
`endif

  // The registers describe the bit currently on w; w_q doubles as the tracker's "last" bit.
  always_comb begin
    // NOTE: every next-state signal gets a default first so no path infers a latch.
    state_d = state_q;
    shreg_d = shreg_q;
    idx_d   = idx_q;
    run2_d  = run2_q;
    w_d     = w_q;
    frame_d = frame_q;
    stuff_d = 1'b0;
    ready_d = ready_q;
`ifdef RUN_LIMIT_TX_PARITY_EN
    par_d      = par_q;
    par_sent_d = par_sent_q;
`endif

    if (state_q == IDLE) begin
      ready_d = 1'b1;
      frame_d = 1'b0;
      w_d     = 1'b0;
      if (bus.valid && ready_q) begin
        state_d = DATA;
        shreg_d = bus.data_in;
        idx_d   = '0;
        run2_d  = 1'b0;
        w_d     = bus.data_in[0];
        frame_d = 1'b1;
        ready_d = 1'b0;
`ifdef RUN_LIMIT_TX_PARITY_EN
        par_d      = ^bus.data_in;
        par_sent_d = 1'b0;
`endif
      end
    end else if (state_q != STUFF && run2_q) begin
      state_d = STUFF;
      w_d     = ~w_q;
      stuff_d = 1'b1;
      run2_d  = 1'b0;
    end else if (idx_q != LAST) begin
      state_d = DATA;
      shreg_d = shreg_q >> 1;
      idx_d   = idx_q + IDX_W'(1);
      w_d     = shreg_q[1];
      run2_d  = (shreg_q[1] == w_q);
`ifdef RUN_LIMIT_TX_PARITY_EN
    end else if (!par_sent_q) begin
      state_d    = PARITY;
      w_d        = par_q;
      run2_d     = (par_q == w_q);
      par_sent_d = 1'b1;
`endif
    end else begin
      state_d = IDLE;
      w_d     = 1'b0;
      frame_d = 1'b0;
      ready_d = 1'b1;
      run2_d  = 1'b0;
    end
  end

  // NOTE: all state, datapath included, is reset so an aborted frame leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      shreg_q <= '0;
      idx_q   <= '0;
      run2_q  <= 1'b0;
      w_q     <= 1'b0;
      frame_q <= 1'b0;
      stuff_q <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values.
      state_q <= state_d;
      shreg_q <= shreg_d;
      idx_q   <= idx_d;
      run2_q  <= run2_d;
      w_q     <= w_d;
      frame_q <= frame_d;
      stuff_q <= stuff_d;
      ready_q <= ready_d;
    end
  end

`ifdef RUN_LIMIT_TX_PARITY_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      par_q      <= 1'b0;
      par_sent_q <= 1'b0;
    end else begin
      par_q      <= par_d;
      par_sent_q <= par_sent_d;
    end
  end
`endif

  assign bus.w     = w_q;
  assign bus.frame = frame_q;
  assign bus.stuff = stuff_q;
  assign bus.ready = ready_q;

endmodule

// File: tb/tb_run_limit_tx.sv
// Directed bench for run_limit_tx (DATA_W=8); expected line patterns are hand-derived.
module tb_run_limit_tx;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  run_limit_tx_if #(.DATA_W(8)) bus ();

  run_limit_tx #(.DATA_W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // Literals list frame cycles left to right: leftmost character is cycle 1.
  task automatic run_frame(input logic [7:0] word, input logic [7:0] after, input logic hold,
                           input logic [15:0] w_exp, input logic [15:0] s_exp, input int len,
                           input string name);
    int waited = 0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    logic [2:0] exp_v;
    bus.data_in = word;
    bus.valid   = 1'b1;
    while (bus.ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL %s ready_timeout ready=%b required=1", name, bus.ready);
      return;
    end
    @(posedge clk); #1;
    bus.data_in = after;
    bus.valid   = hold;
    for (int i = 0; i < len; i++) begin
      exp_v = {1'b1, s_exp[len-1-i], w_exp[len-1-i]};
      checks++;
      if ({bus.frame, bus.stuff, bus.w} !== exp_v) begin
        errors++;
        $display("FAIL %s cycle%0d {frame,stuff,w}=%b required=%b", name, i + 1,
                 {bus.frame, bus.stuff, bus.w}, exp_v);
      end
      if (i >= 2) begin
        checks++;
        if (bus.w === p1 && p1 === p2) begin
          errors++;
          $display("FAIL %s run3 cycle%0d w=%b three equal bits", name, i + 1, bus.w);
        end
      end
      p2 = p1;
      p1 = bus.w;
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.frame, bus.ready, bus.w} !== 3'b010) begin
      errors++;
      $display("FAIL %s idle_after {frame,ready,w}=%b required=010", name,
               {bus.frame, bus.ready, bus.w});
    end
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({bus.w, bus.frame, bus.stuff, bus.ready} !== 4'b0000) begin
      errors++;
      $display("FAIL reset_outputs {w,frame,stuff,ready}=%b required=0000",
               {bus.w, bus.frame, bus.stuff, bus.ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if (bus.ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_release_ready ready=%b required=0", bus.ready);
    end
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_rise ready=%b required=1", bus.ready);
    end
  endtask

  task automatic test_alternating();
`ifdef RUN_LIMIT_TX_PARITY_EN
    run_frame(8'h55, 8'h00, 1'b0, 16'b1010101001, 16'b0000000001, 10, "x55");
`else
    run_frame(8'h55, 8'h00, 1'b0, 16'b10101010, 16'b00000000, 8, "x55");
`endif
  endtask

  task automatic test_zeros();
`ifdef RUN_LIMIT_TX_PARITY_EN
    run_frame(8'h00, 8'hFF, 1'b0, 16'b0010010010010, 16'b0010010010010, 13, "x00");
`else
    run_frame(8'h00, 8'hFF, 1'b0, 16'b001001001001, 16'b001001001001, 12, "x00");
`endif
  endtask

  task automatic test_nibble();
`ifdef RUN_LIMIT_TX_PARITY_EN
    run_frame(8'h0F, 8'hAA, 1'b0, 16'b11011001001001, 16'b00100101001001, 14, "x0F");
`else
    run_frame(8'h0F, 8'hAA, 1'b0, 16'b110110010010, 16'b001001010010, 12, "x0F");
`endif
  endtask

  task automatic test_back_to_back();
`ifdef RUN_LIMIT_TX_PARITY_EN
    run_frame(8'hFF, 8'h55, 1'b1, 16'b11011011011001, 16'b00100100100101, 14, "b2b_xFF");
    run_frame(8'h55, 8'h55, 1'b0, 16'b1010101001, 16'b0000000001, 10, "b2b_x55");
`else
    run_frame(8'hFF, 8'h55, 1'b1, 16'b110110110110, 16'b001001001001, 12, "b2b_xFF");
    run_frame(8'h55, 8'h55, 1'b0, 16'b10101010, 16'b00000000, 8, "b2b_x55");
`endif
  endtask

  task automatic test_low_pair();
`ifdef RUN_LIMIT_TX_PARITY_EN
    run_frame(8'h03, 8'h00, 1'b0, 16'b11001001001001, 16'b00101001001001, 14, "x03");
`else
    run_frame(8'h03, 8'h00, 1'b0, 16'b110010010010, 16'b001010010010, 12, "x03");
`endif
  endtask

  task automatic test_reset_mid_frame();
    int waited = 0;
    bus.data_in = 8'h00;
    bus.valid   = 1'b1;
    while (bus.ready !== 1'b1 && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    @(posedge clk); #1;
    bus.valid = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    checks++;
    if ({bus.frame, bus.w} !== 2'b10) begin
      errors++;
      $display("FAIL midreset_cycle5 {frame,w}=%b required=10", {bus.frame, bus.w});
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({bus.w, bus.frame, bus.stuff, bus.ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midreset_async {w,frame,stuff,ready}=%b required=0000",
               {bus.w, bus.frame, bus.stuff, bus.ready});
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_ready ready=%b required=1", bus.ready);
    end
    test_alternating();
  endtask

  initial begin
    bus.data_in = '0;
    bus.valid   = 1'b0;
    test_reset();
    test_alternating();
    test_zeros();
    test_nibble();
    test_back_to_back();
    test_low_pair();
    test_reset_mid_frame();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
